// File: rtl/tone_sequencer.sv
// Square-wave tone generator that plays a writable table of notes
// (half-period, duration) in order, with optional loop and inter-note gap.
module tone_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DUR_W   = 24,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned GAP_CYC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_period,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] last_idx,
  output logic              speaker,
  output logic              busy,
  output logic [ADDR_W-1:0] note_idx,
  output logic              done
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
  localparam bit          HAS_GAP  = (GAP_CYC != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  tbl_period [DEPTH];
  logic [DUR_W-1:0]  tbl_dur    [DEPTH];

  logic [CNT_W-1:0]  cur_period_q, cur_period_d;
  logic [DUR_W-1:0]  cur_dur_q, cur_dur_d;
  logic [CNT_W-1:0]  tone_cnt_q, tone_cnt_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              loop_q, loop_d;
  logic              speaker_d, busy_d, done_d;
  logic [ADDR_W-1:0] note_idx_d;
  logic              load, adv;
  logic [ADDR_W-1:0] load_idx;

  // Note table: writable in any state, untouched by reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_period[wr_addr] <= wr_period;
      tbl_dur[wr_addr]    <= wr_dur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_period_q <= '0;
      cur_dur_q    <= '0;
      tone_cnt_q   <= '0;
      dur_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      last_q       <= '0;
      loop_q       <= 1'b0;
      speaker      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      note_idx     <= '0;
    end else begin
      state_q      <= state_d;
      cur_period_q <= cur_period_d;
      cur_dur_q    <= cur_dur_d;
      tone_cnt_q   <= tone_cnt_d;
      dur_cnt_q    <= dur_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      last_q       <= last_d;
      loop_q       <= loop_d;
      speaker      <= speaker_d;
      busy         <= busy_d;
      done         <= done_d;
      note_idx     <= note_idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_period_d = cur_period_q;
    cur_dur_d    = cur_dur_q;
    tone_cnt_d   = tone_cnt_q;
    dur_cnt_d    = dur_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    last_d       = last_q;
    loop_d       = loop_q;
    speaker_d    = speaker;
    done_d       = 1'b0;
    note_idx_d   = note_idx;
    load         = 1'b0;
    adv          = 1'b0;
    load_idx     = '0;

    case (state_q)
      IDLE: begin
        speaker_d = 1'b0;
        if (start && !stop) begin
          load   = 1'b1;
          last_d = last_idx;
          loop_d = loop;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d   = IDLE;
          speaker_d = 1'b0;
        end else begin
          if (cur_period_q == '0) begin
            speaker_d = 1'b0;
          end else if (tone_cnt_q == cur_period_q) begin
            tone_cnt_d = '0;
            speaker_d  = ~speaker;
          end else begin
            tone_cnt_d = tone_cnt_q + CNT_W'(1);
          end
          dur_cnt_d = dur_cnt_q + DUR_W'(1);
          if (dur_cnt_q == cur_dur_q) begin
            if (HAS_GAP) begin
              state_d   = GAP;
              speaker_d = 1'b0;
              gap_cnt_d = '0;
            end else begin
              adv = 1'b1;
            end
          end
        end
      end
      GAP: begin
        speaker_d = 1'b0;
        if (stop) begin
          state_d = IDLE;
        end else if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          adv = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // End of a note: next entry, wrap to 0 when looping, or finish
    if (adv) begin
      if (note_idx != last_q) begin
        load     = 1'b1;
        load_idx = note_idx + ADDR_W'(1);
      end else if (loop_q) begin
        load = 1'b1;
      end else begin
        state_d   = IDLE;
        speaker_d = 1'b0;
        done_d    = 1'b1;
      end
    end

    if (load) begin
      state_d      = PLAY;
      cur_period_d = tbl_period[load_idx];
      cur_dur_d    = tbl_dur[load_idx];
      tone_cnt_d   = '0;
      dur_cnt_d    = '0;
      speaker_d    = 1'b0;
      note_idx_d   = load_idx;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed self-checking bench for tone_sequencer: one instance without gap,
// one with GAP_CYC=4, sharing clock, reset and table-write inputs.
module tb_tone_sequencer;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DUR_W  = 24;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_period;
  logic [DUR_W-1:0]  wr_dur;
  logic              start, start_g, stop, loop;
  logic [ADDR_W-1:0] last_idx;
  logic              speaker, busy, done;
  logic [ADDR_W-1:0] note_idx;
  logic              speaker_g, busy_g, done_g;
  logic [ADDR_W-1:0] note_idx_g;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tone_sequencer #(.CNT_W(CNT_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W), .GAP_CYC(0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_period(wr_period), .wr_dur(wr_dur), .start(start), .stop(stop),
    .loop(loop), .last_idx(last_idx), .speaker(speaker), .busy(busy),
    .note_idx(note_idx), .done(done)
  );

  tone_sequencer #(.CNT_W(CNT_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W), .GAP_CYC(4)) dut_g (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_period(wr_period), .wr_dur(wr_dur), .start(start_g), .stop(stop),
    .loop(loop), .last_idx(last_idx), .speaker(speaker_g), .busy(busy_g),
    .note_idx(note_idx_g), .done(done_g)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int p, input int d);
    wr_en     = 1'b1;
    wr_addr   = ADDR_W'(a);
    wr_period = CNT_W'(p);
    wr_dur    = DUR_W'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;
    start = 1'b0; start_g = 1'b0; stop = 1'b0; loop = 1'b0; last_idx = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_speaker", 32'(speaker), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(note_idx), 32'd0);
    chk("rst_busy_g", 32'(busy_g), 32'd0);

    // Basic tone: period 3 -> half-period 4, 16 cycles
    wr(0, 3, 15);
    last_idx = 4'd0; loop = 1'b0;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      chk("basic_busy", 32'(busy), 32'd1);
      chk("basic_spk", 32'(speaker), 32'((i / 4) % 2));
      chk("basic_done", 32'(done), 32'd0);
      tick();
    end
    chk("basic_done_pulse", 32'(done), 32'd1);
    chk("basic_end_busy", 32'(busy), 32'd0);
    chk("basic_end_spk", 32'(speaker), 32'd0);
    tick();
    chk("basic_done_once", 32'(done), 32'd0);

    // Tone then rest, 14 busy cycles
    wr(0, 1, 7);
    wr(1, 0, 5);
    last_idx = 4'd1;
    pulse_start();
    for (int i = 0; i < 14; i++) begin
      chk("seq_busy", 32'(busy), 32'd1);
      chk("seq_idx", 32'(note_idx), (i < 8) ? 32'd0 : 32'd1);
      chk("seq_spk", 32'(speaker), (i < 8) ? 32'((i / 2) % 2) : 32'd0);
      tick();
    end
    chk("seq_done", 32'(done), 32'd1);
    chk("seq_end_busy", 32'(busy), 32'd0);

    // Loop, then stop in the middle of note 1
    loop = 1'b1;
    pulse_start();
    for (int i = 0; i < 28; i++) begin
      chk("loop_idx", 32'(note_idx), ((i % 14) < 8) ? 32'd0 : 32'd1);
      chk("loop_done", 32'(done), 32'd0);
      chk("loop_busy", 32'(busy), 32'd1);
      tick();
    end
    for (int i = 0; i < 9; i++) tick();
    chk("loop_pre_stop_idx", 32'(note_idx), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_spk", 32'(speaker), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    chk("stop_idx_hold", 32'(note_idx), 32'd1);
    tick();
    chk("stop_no_done", 32'(done), 32'd0);

    // Gap instance: 4 PLAY, 4 GAP, 4 PLAY, 4 GAP, done
    wr(0, 1, 3);
    wr(1, 1, 3);
    last_idx = 4'd1; loop = 1'b0;
    start_g = 1'b1;
    tick();
    start_g = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("gap_busy", 32'(busy_g), 32'd1);
      chk("gap_spk", 32'(speaker_g), ((i / 4) % 2 == 0) ? 32'((i % 4) / 2) : 32'd0);
      chk("gap_idx", 32'(note_idx_g), (i < 8) ? 32'd0 : 32'd1);
      chk("gap_done", 32'(done_g), 32'd0);
      tick();
    end
    chk("gap_done_pulse", 32'(done_g), 32'd1);
    chk("gap_end_busy", 32'(busy_g), 32'd0);
    chk("gap_other_idle", 32'(busy), 32'd0);

    // Write to the playing entry takes effect on reload only
    wr(0, 3, 15);
    last_idx = 4'd0; loop = 1'b1;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      chk("wrp_old_spk", 32'(speaker), 32'((i / 4) % 2));
      if (i == 2) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_period = 16'd5; wr_dur = 24'd15;
      end
      if (i == 3) wr_en = 1'b0;
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      chk("wrp_new_spk", 32'(speaker), 32'((i / 6) % 2));
      chk("wrp_idx", 32'(note_idx), 32'd0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("wrp_stop_busy", 32'(busy), 32'd0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd0);
    tick();
    chk("startstop_busy2", 32'(busy), 32'd0);
    chk("startstop_spk", 32'(speaker), 32'd0);

    // Reset in the middle of note 1
    wr(0, 1, 7);
    wr(1, 1, 5);
    last_idx = 4'd1; loop = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    chk("midrst_pre_idx", 32'(note_idx), 32'd1);
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_spk", 32'(speaker), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_idx", 32'(note_idx), 32'd0);
    tick();
    chk("midrst_no_done", 32'(done), 32'd0);

    // Full table, last_idx = DEPTH-1, one-cycle rests
    for (int a = 0; a < 16; a++) wr(a, 0, 0);
    last_idx = 4'd15; loop = 1'b0;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      chk("full_idx", 32'(note_idx), 32'(i));
      chk("full_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("full_done", 32'(done), 32'd1);
    chk("full_end_idx", 32'(note_idx), 32'd15);
    chk("full_end_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
